shift_sched: RTL

SHIFT_SCHED -- requirements
Module: shift_sched

---
 rtl/shift_sched_pkg.sv | 13 +
 rtl/shift_sched_shift_right.sv | 36 +++
 rtl/shift_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/shift_sched_pkg.sv
// Shared types for the shift scheduler: the shift op encoding used on
// the requester ports and inside the pipeline.
package shift_sched_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'd0,
      SHIFT_SRL = 2'd1,
      SHIFT_SRA = 2'd2
   } shift_op_t;

   localparam int SHIFT_OP_W = 2;

endpackage

// File: rtl/shift_sched_shift_right.sv
// shift_right: combinational W-bit barrel shifter (W = 2**LG_W).
// Ports: data_i, dist_i, is_left_i, is_signed_i in; result_o out.
module shift_right #(
   parameter int LG_W = 6,
   localparam int W   = 1 << LG_W
) (
   input  logic [W-1:0]    data_i,
   input  logic [LG_W-1:0] dist_i,
   input  logic            is_left_i,
   input  logic            is_signed_i,
   output logic [W-1:0]    result_o
);

   logic [W-1:0] src;
   logic [W:0]   ext;
   logic [W:0]   shd;

   // Left shifts reuse the right shifter by reversing bits in and out.
   always_comb begin
      src = '0;
      for (int i = 0; i < W; i++) begin
         src[i] = is_left_i ? data_i[W-1-i] : data_i[i];
      end
   end

   assign ext = {is_signed_i & src[W-1], src};
   assign shd = $signed(ext) >>> dist_i;

   always_comb begin
      result_o = '0;
      for (int i = 0; i < W; i++) begin
         result_o[i] = is_left_i ? shd[W-1-i] : shd[i];
      end
   end

endmodule

// File: rtl/shift_sched.sv
// shift_sched: two-requester round-robin shift unit, 2-stage pipeline
// (S1 operand register, S2 result register), fixed latency 2.
// Ports: clk, reset (async, active-low); req_valid/req_ready[1:0] with
// per-requester data/dist/op/word/tag; flush; out_valid/out_ready with
// out_data/out_tag/out_src; busy.
// Option: SHIFT_WORD_OPS_EN enables 32-bit word ops (needs LG_W >= 5).
module shift_sched
   import shift_sched_pkg::*;
#(
   parameter int LG_W  = 6,
   parameter int TAG_W = 6,
   localparam int W    = 1 << LG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [W-1:0]     req_data0,
   input  logic [W-1:0]     req_data1,
   input  logic [LG_W-1:0]  req_dist0,
   input  logic [LG_W-1:0]  req_dist1,
   input  shift_op_t        req_op0,
   input  shift_op_t        req_op1,
   input  logic             req_word0,
   input  logic             req_word1,
   input  logic [TAG_W-1:0] req_tag0,
   input  logic [TAG_W-1:0] req_tag1,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_src,
   output logic             busy
);

   logic             ptr_q, ptr_d;
   logic             s1_v_q, s1_v_d;
   logic [W-1:0]     s1_data_q, s1_data_d;
   logic [LG_W-1:0]  s1_dist_q, s1_dist_d;
   shift_op_t        s1_op_q, s1_op_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
   logic             s1_src_q, s1_src_d;
   logic             s2_v_q, s2_v_d;
   logic [W-1:0]     s2_data_q, s2_data_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
   logic             s2_src_q, s2_src_d;

   logic             win;
   logic             s1_adv;
   logic             s1_free;
   logic             s2_en;
   logic             fire;
   logic [W-1:0]     sh_data;
   logic [LG_W-1:0]  sh_dist;
   logic [W-1:0]     sh_res;
   logic [W-1:0]     res;

   // Pointer holds the last winner; on conflict the other side wins.
   // With a single requester, the valid one wins.
   assign win = (&req_valid) ? ~ptr_q : ~req_valid[0];

   assign s2_en   = ~s2_v_q | out_ready;
   assign s1_adv  = s1_v_q & s2_en;
   assign s1_free = ~s1_v_q | s1_adv;
   assign fire    = (|req_valid) & s1_free & ~flush;

   assign req_ready = fire ? (win ? 2'b10 : 2'b01) : 2'b00;

`ifdef SHIFT_WORD_OPS_EN
   logic s1_word_q, s1_word_d;
   logic fill;

   // Word ops: upper bits pre-filled so the W-bit shifter yields the
   // correct low 32 bits, then the result is sign-extended from bit 31.
   always_comb begin
      sh_data = s1_data_q;
      sh_dist = s1_dist_q;
      fill    = (s1_op_q == SHIFT_SRA) & s1_data_q[31];
      if (s1_word_q) begin
         for (int i = 32; i < W; i++) sh_data[i] = fill;
         sh_dist = LG_W'(s1_dist_q[4:0]);
      end
   end

   always_comb begin
      res = sh_res;
      if (s1_word_q) begin
         for (int i = 32; i < W; i++) res[i] = sh_res[31];
      end
   end

   always_comb begin
      s1_word_d = s1_word_q;
      if (fire) s1_word_d = win ? req_word1 : req_word0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) s1_word_q <= 1'b0;
      else        s1_word_q <= s1_word_d;
   end
`else
   logic unused_word;
   assign unused_word = req_word0 ^ req_word1;
   assign sh_data     = s1_data_q;
   assign sh_dist     = s1_dist_q;
   assign res         = sh_res;
`endif

   shift_right #(
      .LG_W(LG_W)
   ) u_shift (
      .data_i      (sh_data),
      .dist_i      (sh_dist),
      .is_left_i   (s1_op_q == SHIFT_SLL),
      .is_signed_i (s1_op_q == SHIFT_SRA),
      .result_o    (sh_res)
   );

   always_comb begin
      ptr_d     = ptr_q;
      s1_v_d    = s1_v_q;
      s1_data_d = s1_data_q;
      s1_dist_d = s1_dist_q;
      s1_op_d   = s1_op_q;
      s1_tag_d  = s1_tag_q;
      s1_src_d  = s1_src_q;
      s2_v_d    = s2_v_q;
      s2_data_d = s2_data_q;
      s2_tag_d  = s2_tag_q;
      s2_src_d  = s2_src_q;

      if (s1_free) s1_v_d = fire;
      if (fire) begin
         ptr_d     = win;
         s1_data_d = win ? req_data1 : req_data0;
         s1_dist_d = win ? req_dist1 : req_dist0;
         s1_op_d   = win ? req_op1   : req_op0;
         s1_tag_d  = win ? req_tag1  : req_tag0;
         s1_src_d  = win;
      end

      if (s2_en) s2_v_d = s1_v_q;
      if (s1_adv) begin
         s2_data_d = res;
         s2_tag_d  = s1_tag_q;
         s2_src_d  = s1_src_q;
      end

      // Flush kills both stages; no transfer happens, so ptr holds.
      if (flush) begin
         s1_v_d = 1'b0;
         s2_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q     <= 1'b1;
         s1_v_q    <= 1'b0;
         s1_data_q <= '0;
         s1_dist_q <= '0;
         s1_op_q   <= SHIFT_SLL;
         s1_tag_q  <= '0;
         s1_src_q  <= 1'b0;
         s2_v_q    <= 1'b0;
         s2_data_q <= '0;
         s2_tag_q  <= '0;
         s2_src_q  <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         s1_v_q    <= s1_v_d;
         s1_data_q <= s1_data_d;
         s1_dist_q <= s1_dist_d;
         s1_op_q   <= s1_op_d;
         s1_tag_q  <= s1_tag_d;
         s1_src_q  <= s1_src_d;
         s2_v_q    <= s2_v_d;
         s2_data_q <= s2_data_d;
         s2_tag_q  <= s2_tag_d;
         s2_src_q  <= s2_src_d;
      end
   end

   assign out_valid = s2_v_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign out_src   = s2_src_q;
   assign busy      = s1_v_q | s2_v_q;

endmodule
